// File: rtl/uart_usart_pkg.sv
// uart_usart_pkg
//   Shared definitions for the 8N1 USART: register offsets from BASE_ADDR,
//   status bit positions, TX/RX state encodings, bit-timer width and a
//   helper that assembles the status byte.
package uart_usart_pkg;

    localparam logic [7:0] REG_DATA_OFS = 8'h00;
    localparam logic [7:0] REG_STAT_OFS = 8'h01;

    localparam int unsigned STAT_TXRDY = 0;
    localparam int unsigned STAT_RXRDY = 1;
    localparam int unsigned STAT_OE    = 2;
    localparam int unsigned STAT_FE    = 3;

    localparam int unsigned TIMER_W = 16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [7:0] status_word(input logic fe, input logic oe,
                                               input logic rx_rdy, input logic tx_rdy);
        logic [7:0] s;
        s             = '0;
        s[STAT_TXRDY] = tx_rdy;
        s[STAT_RXRDY] = rx_rdy;
        s[STAT_OE]    = oe;
        s[STAT_FE]    = fe;
        return s;
    endfunction

endpackage

// File: rtl/uart_usart_rx.sv
// uart_rx
//   Receiver: 2-flop synchroniser on rxd, start-edge detection, mid-bit
//   sampling of start, 8 data bits (LSB first) and stop bit.
//   Ports:
//     clk, n_rst  - clock, asynchronous active-low reset
//     rxd         - asynchronous serial input
//     byte_valid  - one-cycle pulse on the stop-bit sample edge
//     rx_byte     - received byte, valid while byte_valid is high
//     frame_err   - stop bit sampled as 0, valid with byte_valid
module uart_rx
    import uart_usart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 104
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLK_DIV - 1);
    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLK_DIV / 2 - 1);

    logic               rxd_meta;
    logic               rxd_sync;
    logic               rxd_prev;
    rx_state_t          state;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic               bit_end;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign bit_end = (timer == BIT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= RX_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    timer <= '0;
                    if (rxd_prev && !rxd_sync) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (timer == HALF_LAST) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        // A high line at mid start-bit is a glitch.
                        state   <= rxd_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_end) begin
                        timer   <= '0;
                        shreg   <= {rxd_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        state <= RX_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // Decoded from the stop-sample condition so delivery lands on that edge.
    assign byte_valid = (state == RX_STOP) && bit_end;
    assign frame_err  = byte_valid && !rxd_sync;
    assign rx_byte    = shreg;

endmodule

// File: rtl/uart_usart.sv
// uart_usart
//   Minimal 8N1 USART on the Z80 I/O bus. Data register at BASE_ADDR,
//   status register {4'b0, FE, OE, RxRDY, TxRDY} at BASE_ADDR+1.
//   Double-buffered transmitter; receiver lives in uart_rx.
//   Ports:
//     clk, n_rst        - clock, asynchronous active-low reset
//     iorq_n,rd_n,wr_n  - Z80 I/O request / read / write strobes (active low)
//     addr, data_in     - I/O port address and CPU write data
//     data_out, data_oe - read data and bus drive enable
//     txd, rxd          - serial out (idles 1) / asynchronous serial in
module uart_usart
    import uart_usart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 104,
    parameter logic [7:0]  BASE_ADDR = 8'h84
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       txd,
    input  logic       rxd
);

    localparam logic [7:0]         DATA_ADDR = BASE_ADDR + REG_DATA_OFS;
    localparam logic [7:0]         STAT_ADDR = BASE_ADDR + REG_STAT_OFS;
    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLK_DIV - 1);

    // Bus decode
    logic data_hit;
    logic stat_hit;
    logic rd_sel;
    logic data_rd_sel;
    logic data_wr_sel;
    logic data_rd_d;
    logic data_wr_d;
    logic rd_fall;
    logic wr_rise;

    // Transmitter
    tx_state_t          tx_state;
    logic [TIMER_W-1:0] tx_timer;
    logic [2:0]         tx_bit;
    logic [7:0]         tx_shift;
    logic [7:0]         tx_hold;
    logic               tx_rdy;
    logic               tx_bit_end;

    // Receiver / status
    logic       rx_rdy;
    logic       oe;
    logic       fe;
    logic [7:0] rx_buf;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    assign data_hit    = (addr == DATA_ADDR);
    assign stat_hit    = (addr == STAT_ADDR);
    assign rd_sel      = !iorq_n && !rd_n && (data_hit || stat_hit);
    assign data_rd_sel = !iorq_n && !rd_n && data_hit;
    assign data_wr_sel = !iorq_n && !wr_n && data_hit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_rd_d <= 1'b0;
            data_wr_d <= 1'b0;
        end else begin
            data_rd_d <= data_rd_sel;
            data_wr_d <= data_wr_sel;
        end
    end

    assign rd_fall = data_rd_d && !data_rd_sel;
    assign wr_rise = data_wr_sel && !data_wr_d;

    always_comb begin
        data_out = '0;
        if (rd_sel) begin
            data_out = data_hit ? rx_buf : status_word(fe, oe, rx_rdy, tx_rdy);
        end
    end

    assign data_oe = rd_sel;

    assign tx_bit_end = (tx_timer == BIT_LAST);

    // tx_rdy is written both by the CPU write and by the holding->shifter
    // transfer; the two are mutually exclusive because one needs tx_rdy=1
    // and the other tx_rdy=0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_state <= TX_IDLE;
            tx_timer <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_hold  <= '0;
            tx_rdy   <= 1'b1;
            txd      <= 1'b1;
        end else begin
            if (wr_rise && tx_rdy) begin
                tx_hold <= data_in;
                tx_rdy  <= 1'b0;
            end
            case (tx_state)
                TX_IDLE: begin
                    tx_timer <= '0;
                    if (!tx_rdy) begin
                        tx_shift <= tx_hold;
                        tx_rdy   <= 1'b1;
                        txd      <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_timer <= '0;
                        tx_bit   <= '0;
                        txd      <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_timer <= '0;
                        tx_bit   <= tx_bit + 1'b1;
                        if (tx_bit == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            txd      <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_timer <= '0;
                        // A pending byte starts immediately: no idle gap.
                        if (!tx_rdy) begin
                            tx_shift <= tx_hold;
                            tx_rdy   <= 1'b1;
                            txd      <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_timer <= tx_timer + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    uart_rx #(
        .CLK_DIV(CLK_DIV)
    ) u_rx (
        .clk       (clk),
        .n_rst     (n_rst),
        .rxd       (rxd),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
    );

    // Data-read completion clears the flags first; a delivery in the same
    // cycle then wins, so the new byte lands and OE stays clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_rdy <= 1'b0;
            oe     <= 1'b0;
            fe     <= 1'b0;
            rx_buf <= '0;
        end else begin
            if (rd_fall) begin
                rx_rdy <= 1'b0;
                oe     <= 1'b0;
                fe     <= 1'b0;
            end
            if (byte_valid) begin
                if (frame_err) begin
                    fe <= 1'b1;
                end
                if (!rx_rdy || rd_fall) begin
                    rx_buf <= rx_byte;
                    rx_rdy <= 1'b1;
                end else begin
                    oe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_usart.sv
// tb_uart_usart
//   Scoreboard bench for uart_usart with CLK_DIV=16. Bus reads push their
//   expected byte; a monitor pops and compares whenever data_oe is high.
//   Writes push the expected serial byte; a txd monitor decodes frames
//   cycle by cycle and compares every bit period.
module tb_uart_usart;

    localparam int unsigned CLK_DIV = 16;
    localparam int unsigned FRAME   = 10 * CLK_DIV;
    localparam int unsigned PERIOD  = 10;

    logic       clk     = 1'b0;
    logic       n_rst   = 1'b0;
    logic       iorq_n  = 1'b1;
    logic       rd_n    = 1'b1;
    logic       wr_n    = 1'b1;
    logic [7:0] addr    = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       rxd     = 1'b1;
    logic [7:0] data_out;
    logic       data_oe;
    logic       txd;

    uart_usart #(
        .CLK_DIV  (CLK_DIV),
        .BASE_ADDR(8'h84)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .iorq_n  (iorq_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .data_oe (data_oe),
        .txd     (txd),
        .rxd     (rxd)
    );

    always #(PERIOD / 2) clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] data;
        string      tag;
    } rd_exp_t;

    rd_exp_t    rd_exp[$];
    logic [7:0] tx_exp[$];
    int         tm_starts[$];
    bit         poll_active = 1'b0;

    // ---------------- read scoreboard monitor ----------------
    always @(negedge clk) begin
        rd_exp_t e;
        if (n_rst && !poll_active) begin
            if (data_oe) begin
                checks++;
                if (rd_exp.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: data_oe high with data %02h, no read issued", data_out);
                end else begin
                    e = rd_exp.pop_front();
                    if (data_out !== e.data) begin
                        errors++;
                        $display("FAIL %s: data_out=%02h expected %02h", e.tag, data_out, e.data);
                    end
                end
            end else begin
                checks++;
                if (data_out !== 8'h00) begin
                    errors++;
                    $display("FAIL data_out_idle: data_out=%02h expected 00 with data_oe low", data_out);
                end
            end
        end
    end

    // ---------------- txd frame monitor ----------------
    function automatic logic frame_bit(input logic [7:0] b, input int unsigned i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    bit          tm_active = 1'b0;
    int unsigned tm_bit    = 0;
    int unsigned tm_cnt    = 0;
    int unsigned tm_bad    = 0;
    logic [7:0]  tm_exp    = 8'h00;

    always @(negedge clk) begin
        if (!n_rst) begin
            tm_active = 1'b0;
        end else if (!tm_active) begin
            if (txd === 1'b0) begin
                tm_active = 1'b1;
                tm_bit    = 0;
                tm_cnt    = 1;
                tm_bad    = 0;
                tm_starts.push_back(cyc);
                if (tx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    tm_exp = 8'h00;
                    $display("FAIL tx_spurious: txd frame started at cycle %0d, expected idle 1", cyc);
                end else begin
                    tm_exp = tx_exp.pop_front();
                end
            end
        end else begin
            if (txd !== frame_bit(tm_exp, tm_bit)) tm_bad++;
            tm_cnt++;
        end
        if (tm_active && tm_cnt == CLK_DIV) begin
            checks++;
            if (tm_bad != 0) begin
                errors++;
                $display("FAIL tx_bit: byte %02h bit %0d had %0d wrong samples, required %0d cycles of %0b",
                         tm_exp, tm_bit, tm_bad, CLK_DIV, frame_bit(tm_exp, tm_bit));
            end
            tm_bit++;
            tm_cnt = 0;
            tm_bad = 0;
            if (tm_bit == 10) tm_active = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check_int(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        addr    = a;
        data_in = d;
        iorq_n  = 1'b0;
        wr_n    = 1'b0;
        @(posedge clk);
        #1;
        iorq_n = 1'b1;
        wr_n   = 1'b1;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
        rd_exp_t e;
        e.data = exp;
        e.tag  = tag;
        rd_exp.push_back(e);
        addr   = a;
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        @(posedge clk);
        #1;
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic poll_txrdy();
        bit ready;
        ready       = 1'b0;
        poll_active = 1'b1;
        for (int i = 0; i < 400 && !ready; i++) begin
            addr   = 8'h85;
            iorq_n = 1'b0;
            rd_n   = 1'b0;
            @(negedge clk);
            ready = data_out[0];
            @(posedge clk);
            #1;
            iorq_n = 1'b1;
            rd_n   = 1'b1;
            @(posedge clk);
            #1;
        end
        poll_active = 1'b0;
        checks++;
        if (!ready) begin
            errors++;
            $display("FAIL poll_txrdy: TxRDY=0 after 400 polls, required 1");
        end
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while ((tx_exp.size() != 0 || tm_active) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL tx_drain: %0d frames still pending after 4000 cycles, required 0", tx_exp.size());
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        #(CLK_DIV * PERIOD);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(CLK_DIV * PERIOD);
        end
        rxd = stop;
        #(CLK_DIV * PERIOD);
        rxd = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_txd", int'(txd), 1);
        check_int("reset_data_oe", int'(data_oe), 0);
        n_rst = 1'b1;
        idle(2);

        bus_read(8'h85, 8'h01, "reset_status");
        bus_read(8'h84, 8'h00, "reset_rx_buf");

        // Single byte 0x4F; TxRDY low only until the shifter loads.
        tx_exp.push_back(8'h4F);
        bus_write(8'h84, 8'h4F);
        bus_read(8'h85, 8'h00, "txrdy_after_write");
        bus_read(8'h85, 8'h01, "txrdy_reloaded");
        wait_tx_idle();

        // Third write arrives while holding is full and is dropped.
        tx_exp.push_back(8'hA1);
        tx_exp.push_back(8'hB2);
        bus_write(8'h84, 8'hA1);
        idle(1);
        bus_write(8'h84, 8'hB2);
        idle(1);
        bus_write(8'h84, 8'hC3);
        idle(1);
        bus_read(8'h85, 8'h00, "txrdy_hold_full");
        wait_tx_idle();
        bus_read(8'h85, 8'h01, "txrdy_after_drop");

        // Three polled back-to-back frames must be contiguous.
        tm_starts.delete();
        poll_txrdy(); tx_exp.push_back(8'h11); bus_write(8'h84, 8'h11); idle(1);
        poll_txrdy(); tx_exp.push_back(8'h22); bus_write(8'h84, 8'h22); idle(1);
        poll_txrdy(); tx_exp.push_back(8'h33); bus_write(8'h84, 8'h33); idle(1);
        wait_tx_idle();
        check_int("b2b_frame_count", tm_starts.size(), 3);
        if (tm_starts.size() == 3) begin
            check_int("b2b_gap_1_2", tm_starts[1] - tm_starts[0], FRAME);
            check_int("b2b_gap_2_3", tm_starts[2] - tm_starts[1], FRAME);
        end

        // Status-register write has no effect.
        bus_write(8'h85, 8'hFF);
        idle(1);
        bus_read(8'h85, 8'h01, "stat_write_ignored");
        idle(FRAME);

        // Good receive.
        send_rx(8'h4B, 1'b1);
        bus_read(8'h85, 8'h03, "rx_status_ready");
        bus_read(8'h84, 8'h4B, "rx_data_4b");
        bus_read(8'h85, 8'h01, "rx_status_cleared");

        // Overrun: second byte discarded.
        send_rx(8'h41, 1'b1);
        send_rx(8'h42, 1'b1);
        bus_read(8'h85, 8'h07, "rx_status_overrun");
        bus_read(8'h84, 8'h41, "rx_data_kept_41");
        bus_read(8'h85, 8'h01, "rx_overrun_cleared");

        // Framing error, byte still delivered.
        send_rx(8'h55, 1'b0);
        idle(4);
        bus_read(8'h85, 8'h0B, "rx_status_frame_err");
        bus_read(8'h84, 8'h55, "rx_data_55");
        bus_read(8'h85, 8'h01, "rx_fe_cleared");

        // Short low glitch is rejected; a real frame afterwards is received.
        rxd = 1'b0;
        #(4 * PERIOD);
        rxd = 1'b1;
        #(3 * FRAME * PERIOD);
        bus_read(8'h85, 8'h01, "rx_glitch_ignored");
        send_rx(8'hA5, 1'b1);
        bus_read(8'h85, 8'h03, "rx_after_glitch_ready");
        bus_read(8'h84, 8'hA5, "rx_data_a5");

        // Reset in the middle of a frame (inside data bit 0 of 0x3C).
        tx_exp.push_back(8'h3C);
        bus_write(8'h84, 8'h3C);
        idle(30);
        check_int("txd_mid_frame", int'(txd), 0);
        #3;
        n_rst = 1'b0;
        #1;
        check_int("txd_async_reset", int'(txd), 1);
        idle(3);
        n_rst = 1'b1;
        idle(2);
        bus_read(8'h85, 8'h01, "status_after_reset");
        bus_read(8'h84, 8'h00, "rx_buf_after_reset");
        idle(2 * FRAME);

        check_int("rd_queue_drained", rd_exp.size(), 0);
        check_int("tx_queue_drained", tx_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #(50000 * PERIOD);
        $display("FAIL watchdog: simulation exceeded 50000 cycles, required completion");
        $fatal(1, "watchdog");
    end

endmodule
